// File: rtl/ks_pkg.sv
// Shared Kogge-Stone types and helpers for the 4-bit add/sub datapath.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package ks_pkg;

  localparam int KS_W    = 4;
  localparam int KS_LVLS = 2;

  // One prefix node: group generate and group propagate.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Kogge-Stone black cell: merges a high group with the adjacent lower group.
  function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix4.sv
// Combinational 2-level Kogge-Stone carry prefix for 4 bits with carry-in.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline owns flow control.
module ks_prefix4
  import ks_pkg::*;
(
  input  logic [KS_W-1:0] g,
  input  logic [KS_W-1:0] p,
  input  logic            cin,
  output logic [KS_W:0]   c
);

  gp_t [KS_W-1:0] lvl0;
  gp_t [KS_W-1:0] lvl1;
  gp_t [KS_W-1:0] lvl2;

  // Only the group-generate terms reach the carries; the low propagates
  // of the last levels are structurally dead and collected here.
  logic unused_p;
  assign unused_p = &{1'b0, lvl2[3].p, lvl2[2].p, lvl2[1].p, lvl2[0].p};

  // Fold cin into bit 0, then span-1 and span-2 prefix levels.
  always_comb begin
    for (int i = 0; i < KS_W; i++) begin
      lvl0[i] = {g[i], p[i]};
    end
    lvl0[0].g = g[0] | (p[0] & cin);

    lvl1[0] = lvl0[0];
    for (int i = 1; i < KS_W; i++) begin
      lvl1[i] = gp_merge(lvl0[i], lvl0[i-1]);
    end

    lvl2[0] = lvl1[0];
    lvl2[1] = lvl1[1];
    for (int i = 2; i < KS_W; i++) begin
      lvl2[i] = gp_merge(lvl1[i], lvl1[i-2]);
    end

    c[0] = cin;
    for (int i = 0; i < KS_W; i++) begin
      c[i+1] = lvl2[i].g;
    end
  end

endmodule

// File: rtl/sub4_ks_pipe.sv
// Pipelined 4-bit Kogge-Stone subtractor d = a + ~b + 1 with borrow-out and signed overflow.
// Latency: 2 cycles from accept to out_valid; throughput 1 result per cycle.
// Backpressure: out_ready low freezes stage 2, stage 1 then fills and in_ready drops.
module sub4_ks_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  // Stage 1: bitwise propagate/generate of a and ~b, plus sign bits for overflow.
  logic [KS_W-1:0] p1_q, p1_d;
  logic [KS_W-1:0] g1_q, g1_d;
  logic            a3_q, a3_d;
  logic            b3_q, b3_d;
  logic            s1_v_q, s1_v_d;

  // Stage 2: final results.
  logic [KS_W-1:0] d_q, d_d;
  logic            bo_q, bo_d;
  logic            ovf_q, ovf_d;
  logic            s2_v_q, s2_v_d;

  logic            s1_adv, s2_adv, accept;
  logic [KS_W-1:0] b_n;
  logic [KS_W-1:0] diff;
  logic [KS_W:0]   c;

  // Subtraction is addition of the inverted subtrahend with carry-in tied high.
  ks_prefix4 u_prefix (
    .g   (g1_q),
    .p   (p1_q),
    .cin (1'b1),
    .c   (c)
  );

  // Handshake: a stage advances when it is empty or the stage after it advances.
  always_comb begin
    s2_adv   = ~s2_v_q | out_ready;
    s1_adv   = ~s1_v_q | s2_adv;
    in_ready = s1_adv;
    accept   = in_valid & s1_adv;
    b_n      = ~b;
  end

  // Stage 1 next state: load operands on accept, insert a bubble when advancing idle.
  always_comb begin
    p1_d   = p1_q;
    g1_d   = g1_q;
    a3_d   = a3_q;
    b3_d   = b3_q;
    s1_v_d = s1_v_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
    end
    if (accept) begin
      p1_d = a ^ b_n;
      g1_d = a & b_n;
      a3_d = a[KS_W-1];
      b3_d = b[KS_W-1];
    end
  end

  // Stage 2 next state: sum bits, borrow = inverted carry-out, signed overflow.
  always_comb begin
    diff   = p1_q ^ c[KS_W-1:0];
    d_d    = d_q;
    bo_d   = bo_q;
    ovf_d  = ovf_q;
    s2_v_d = s2_v_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        d_d   = diff;
        bo_d  = ~c[KS_W];
        ovf_d = (a3_q ^ b3_q) & (diff[KS_W-1] ^ a3_q);
      end
    end
  end

  // Pipeline registers; reset drops all in-flight work and clears the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q   <= '0;
      g1_q   <= '0;
      a3_q   <= 1'b0;
      b3_q   <= 1'b0;
      s1_v_q <= 1'b0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      ovf_q  <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      p1_q   <= p1_d;
      g1_q   <= g1_d;
      a3_q   <= a3_d;
      b3_q   <= b3_d;
      s1_v_q <= s1_v_d;
      d_q    <= d_d;
      bo_q   <= bo_d;
      ovf_q  <= ovf_d;
      s2_v_q <= s2_v_d;
    end
  end

  assign out_valid = s2_v_q;
  assign d         = d_q;
  assign bo        = bo_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub4_ks_pipe.sv
// Self-checking bench for sub4_ks_pipe: directed vectors, streaming, backpressure, reset, exhaustive.
// Latency: checks the 2-edge accept-to-out_valid timing.
// Backpressure: drives out_ready stalls and holds operands while in_ready is low.
module tb_sub4_ks_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] d;
  logic       bo;
  logic       ovf;

  always #5 clk = ~clk;

  sub4_ks_pipe #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo),
    .ovf       (ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] d;
    logic       bo;
    logic       ovf;
  } res_t;

  // Golden model from plain integer arithmetic.
  function automatic res_t model(input logic [3:0] x, input logic [3:0] y);
    res_t r;
    int   sx, sy, ds;
    sx    = x[3] ? int'(x) - 16 : int'(x);
    sy    = y[3] ? int'(y) - 16 : int'(y);
    ds    = sx - sy;
    r.d   = x - y;
    r.bo  = (x < y);
    r.ovf = (ds > 7) || (ds < -8);
    return r;
  endfunction

  res_t exp_q[$];
  res_t mon_e;
  int   n_in   = 0;
  int   n_out  = 0;
  int   n_lost = 0;
  bit   mon_en = 1'b0;

  // Scoreboard: record transfers in the middle of each cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("sb_extra_result", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_result", {26'd0, d, bo, ovf}, {26'd0, mon_e});
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                       input logic ordy, output logic rdy_seen, output logic ov_seen);
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = ordy;
    @(negedge clk);
    rdy_seen = in_ready;
    ov_seen  = out_valid;
    @(posedge clk);
    #1;
  endtask

  // Directed vectors with hand-computed results.
  logic [3:0] ta [8] = '{4'h5, 4'h3, 4'h0, 4'h8, 4'h7, 4'h0, 4'h0, 4'hF};
  logic [3:0] tb [8] = '{4'h3, 4'h5, 4'h0, 4'h1, 4'h8, 4'h1, 4'h8, 4'hF};
  logic [3:0] td [8] = '{4'h2, 4'hE, 4'h0, 4'h7, 4'hF, 4'hF, 4'h8, 4'h0};
  logic       tbo[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       tov[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       r, o;
    logic [3:0] held_d;
    int         idx, first, last, cnt_ov, cyc;
    bit         rdy_low;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 4'h0;
    b         = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_d", d, 4'h0);
    chk("rst_bo", bo, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single operations: output appears two edges after presentation.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, ta[k], tb[k], 1'b1, r, o);
      chk($sformatf("dir%0d_in_ready", k), r, 1'b1);
      chk($sformatf("dir%0d_lat1_valid", k), out_valid, 1'b0);
      drive(1'b0, 4'h0, 4'h0, 1'b1, r, o);
      chk($sformatf("dir%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("dir%0d_d", k), d, td[k]);
      chk($sformatf("dir%0d_bo", k), bo, tbo[k]);
      chk($sformatf("dir%0d_ovf", k), ovf, tov[k]);
      drive(1'b0, 4'h0, 4'h0, 1'b1, r, o);
    end

    // Back-to-back stream of 16.
    first = -1; last = -1; cnt_ov = 0; rdy_low = 1'b0;
    for (int c2 = 0; c2 < 20; c2++) begin
      if (c2 < 16) drive(1'b1, 4'(c2), 4'(c2 * 5 + 9), 1'b1, r, o);
      else         drive(1'b0, 4'h0, 4'h0, 1'b1, r, o);
      if (c2 < 16 && !r) rdy_low = 1'b1;
      if (o) begin
        cnt_ov++;
        if (first < 0) first = c2;
        last = c2;
      end
    end
    chk("b2b_in_ready_low", {31'd0, rdy_low}, 32'd0);
    chk("b2b_valid_count", cnt_ov, 32'd16);
    chk("b2b_valid_span", last - first + 1, 32'd16);
    chk("b2b_sb_empty", exp_q.size(), 32'd0);

    // Backpressure: out_ready low for 3 cycles mid-stream.
    idx = 0;
    held_d = 4'h0;
    for (int c2 = 0; c2 < 24; c2++) begin
      if (c2 == 5) held_d = d;
      drive(idx < 12, 4'(idx * 3 + 1), 4'(15 - idx), !(c2 >= 5 && c2 <= 7), r, o);
      if (idx < 12 && r) idx++;
      if (c2 >= 5 && c2 <= 7) begin
        chk($sformatf("bp_in_ready_c%0d", c2), r, 1'b0);
        chk($sformatf("bp_valid_c%0d", c2), out_valid, 1'b1);
        chk($sformatf("bp_d_hold_c%0d", c2), d, held_d);
      end
    end
    chk("bp_all_accepted", idx, 32'd12);
    chk("bp_sb_empty", exp_q.size(), 32'd0);

    // Asynchronous reset between edges with both stages full.
    drive(1'b1, 4'h2, 4'h1, 1'b1, r, o);
    drive(1'b1, 4'h4, 4'h1, 1'b1, r, o);
    chk("arst_pre_valid", out_valid, 1'b1);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_d", d, 4'h0);
    chk("arst_bo", bo, 1'b0);
    mon_en = 1'b0;
    n_lost = n_lost + exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("arst_hold_valid", out_valid, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 4'h9, 4'h4, 1'b1, r, o);
    chk("arst_lat1_valid", out_valid, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b1, r, o);
    chk("arst_new_valid", out_valid, 1'b1);
    chk("arst_new_d", d, 4'h5);
    chk("arst_new_bo", bo, 1'b0);
    chk("arst_new_ovf", ovf, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b1, r, o);

    // Exhaustive operand pairs with random valid/ready stalls.
    idx = 0;
    cyc = 0;
    while (idx < 256 && cyc < 3000) begin
      drive($urandom_range(0, 9) < 7, idx[7:4], idx[3:0], $urandom_range(0, 9) < 7, r, o);
      if (in_valid && r) idx++;
      cyc++;
    end
    chk("rnd_all_accepted", idx, 32'd256);
    for (int c2 = 0; c2 < 4; c2++) drive(1'b0, 4'h0, 4'h0, 1'b1, r, o);
    chk("rnd_sb_empty", exp_q.size(), 32'd0);
    chk("sb_balance", n_out + n_lost, n_in);
    chk("end_out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
